// File: rtl/m_dctr8_reload_if.sv
// Data/control bundle for the 8-bit reloadable down-counter.
// The master drives preset/load/enable/mode; the counter returns count and status.
interface m_dctr8_reload_if;
    logic [7:0] D;
    logic       LDL;
    logic       ENAB;
    logic       AUTO;
    logic [7:0] Q;
    logic [7:0] QL;
    logic       ZERO;
    logic       BORROW;
    logic       TC;
    logic       RUNNING;

    modport master (
        output D, LDL, ENAB, AUTO,
        input  Q, QL, ZERO, BORROW, TC, RUNNING
    );

    modport slave (
        input  D, LDL, ENAB, AUTO,
        output Q, QL, ZERO, BORROW, TC, RUNNING
    );
endinterface

// File: rtl/m_dctr8_reload.sv
// 8-bit loadable down-counter with a reload register, terminal-count pulse and
// optional auto-reload; period is D+1 enabled ticks.
module m_dctr8_reload (
    input  logic             CK,
    input  logic             RESET,
    m_dctr8_reload_if.slave  bus
);

    typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

    state_t     state, state_next;
    logic [7:0] count, count_next;
    logic [7:0] reload, reload_next;
    logic       tc, tc_next;

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            state  <= STOP;
            count  <= 8'h00;
            reload <= 8'h00;
            tc     <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            reload <= reload_next;
            tc     <= tc_next;
        end
    end

    // Load beats everything; otherwise only enabled ticks in RUN move the counter.
    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload;
        tc_next     = 1'b0;
        if (!bus.LDL) begin
            reload_next = bus.D;
            count_next  = bus.D;
            state_next  = RUN;
        end else if (state == RUN && bus.ENAB) begin
            if (count != 8'h00) begin
                count_next = count - 8'h01;
            end else begin
                tc_next = 1'b1;
                if (bus.AUTO) begin
                    count_next = reload;
                end else begin
                    state_next = STOP;
                end
            end
        end
    end

    assign bus.Q       = count;
    assign bus.QL      = ~count;
    assign bus.ZERO    = (count == 8'h00);
    assign bus.RUNNING = (state == RUN);
    assign bus.BORROW  = (state == RUN) && bus.ENAB && (count == 8'h00);
    assign bus.TC      = tc;

endmodule

// File: tb/tb_m_dctr8_reload.sv
// Self-checking bench for m_dctr8_reload: directed scenarios followed by a random
// phase, all compared against a period/elapsed-ticks reference model.
module tb_m_dctr8_reload;

    logic CK;
    logic RESET;
    int   testsRun;
    int   testsFailed;

    m_dctr8_reload_if bus ();

    m_dctr8_reload dut (
        .CK    (CK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Reference model: the current interval length (reload value) and how many
    // enabled ticks of it have elapsed; the count is their difference.
    int   mRld;
    int   mElapsed;
    bit   mRun;
    bit   mTc;

    function automatic logic [7:0] modelQ();
        return 8'(mRld - mElapsed);
    endfunction

    task automatic modelReset();
        mRld     = 0;
        mElapsed = 0;
        mRun     = 1'b0;
        mTc      = 1'b0;
    endtask

    task automatic modelEdge(input logic ldl, input logic [7:0] d, input logic en, input logic au);
        mTc = 1'b0;
        if (!ldl) begin
            mRld     = d;
            mElapsed = 0;
            mRun     = 1'b1;
        end else if (mRun && en) begin
            if (mElapsed == mRld) begin
                mTc = 1'b1;
                if (au) mElapsed = 0;
                else    mRun = 1'b0;
            end else begin
                mElapsed++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] q;
        q = modelQ();
        chk({tag, " Q"},       bus.Q,                q);
        chk({tag, " QL"},      bus.QL,               ~q);
        chk({tag, " ZERO"},    8'(bus.ZERO),         8'(q == 8'h00));
        chk({tag, " TC"},      8'(bus.TC),           8'(mTc));
        chk({tag, " RUNNING"}, 8'(bus.RUNNING),      8'(mRun));
    endtask

    // Drive one cycle's inputs, check the combinational BORROW before the edge,
    // then advance the model with the edge and check the registered outputs.
    task automatic applyStimulus(input string tag, input logic ldl, input logic [7:0] d,
                                 input logic en, input logic au);
        bus.LDL  = ldl;
        bus.D    = d;
        bus.ENAB = en;
        bus.AUTO = au;
        #1;
        chk({tag, " BORROW"}, 8'(bus.BORROW), 8'(mRun && en && (modelQ() == 8'h00)));
        @(posedge CK);
        modelEdge(ldl, d, en, au);
        #1;
        checkOutput(tag);
    endtask

    int edges;
    int tcCount;
    bit seen;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        bus.LDL  = 1'b1;
        bus.D    = 8'h00;
        bus.ENAB = 1'b0;
        bus.AUTO = 1'b0;
        RESET    = 1'b1;
        modelReset();
        repeat (2) @(posedge CK);
        #2;
        checkOutput("reset");
        RESET = 1'b0;

        // Run to 0x37 then reset asynchronously mid-cycle.
        applyStimulus("preload", 1'b0, 8'h40, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus("pre", 1'b1, 8'h00, 1'b1, 1'b1);
        chk("at37", bus.Q, 8'h37);
        #2;
        RESET = 1'b1;
        modelReset();
        #1;
        checkOutput("asyncReset");
        @(posedge CK);
        #2;
        RESET = 1'b0;

        // One-shot D=3.
        applyStimulus("osLoad", 1'b0, 8'h03, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus("osRun", 1'b1, 8'h00, 1'b1, 1'b0);
        chk("osTcQ", bus.Q, 8'h00);
        chk("osTcRun", 8'(bus.RUNNING), 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus("osIdle", 1'b1, 8'h9A, i[0], 1'b1);

        // Auto-reload D=2: ten terminal pulses in 30 edges.
        applyStimulus("arLoad", 1'b0, 8'h02, 1'b1, 1'b1);
        tcCount = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus("arRun", 1'b1, 8'h00, 1'b1, 1'b1);
            if (bus.TC) tcCount++;
        end
        chk("arTcCount", 8'(tcCount), 8'd10);

        // Gated enable D=0x10, enable on every second edge.
        applyStimulus("gtLoad", 1'b0, 8'h10, 1'b1, 1'b0);
        seen  = 1'b0;
        edges = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            applyStimulus("gtRun", 1'b1, 8'h00, (i % 2) == 0, 1'b0);
            if (bus.TC) begin seen = 1'b1; edges = i; end
        end
        chk("gtEdges", 8'(edges), 8'd34);

        // D=0 with auto: TC on every enabled edge.
        applyStimulus("d0Load", 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus("d0Run", 1'b1, 8'h00, 1'b1, 1'b1);
            chk("d0Tc", 8'(bus.TC), 8'h01);
        end

        // D=0xFF: 256 enabled edges to TC.
        applyStimulus("ffLoad", 1'b0, 8'hFF, 1'b1, 1'b0);
        seen  = 1'b0;
        edges = 0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            applyStimulus("ffRun", 1'b1, 8'h00, 1'b1, 1'b0);
            if (bus.TC) begin seen = 1'b1; edges = i; end
        end
        testsRun++;
        assert (edges == 256) else begin
            testsFailed++;
            $error("FAIL ffEdges: observed %0d expected 256", edges);
        end

        // Load on the terminal edge wins.
        applyStimulus("ltLoad", 1'b0, 8'h01, 1'b1, 1'b1);
        applyStimulus("ltRun", 1'b1, 8'h00, 1'b1, 1'b1);
        applyStimulus("ltTerm", 1'b0, 8'h05, 1'b1, 1'b1);
        chk("ltQ", bus.Q, 8'h05);
        chk("ltTc", 8'(bus.TC), 8'h00);
        chk("ltRun", 8'(bus.RUNNING), 8'h01);

        // Reload integrity: D wanders on non-load cycles, every reload is 4.
        applyStimulus("riLoad", 1'b0, 8'h04, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("riRun", 1'b1, 8'($urandom), 1'b1, 1'b1);
            if (bus.TC) chk("riReload", bus.Q, 8'h04);
        end

        // Random phase.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rnd", ($urandom_range(0, 15) != 0), 8'($urandom_range(0, 12)),
                          1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
